// File: rtl/sr_pulse_pkg.sv
// sr_pulse_pkg: shared FSM state encoding and default parameter values for sr_pulse_gen
package sr_pulse_pkg;
  typedef enum logic [2:0] {INIT, IDLE, PULSE_S, PULSE_R, WAIT_REL} state_t;
  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_PULSE_W = 1;
endpackage

// File: rtl/sr_debounce.sv
// sr_debounce: two-flop sync of raw_in, then counter debounce to level db (ports: clk, rst_n, raw_in -> db)
module sr_debounce
  import sr_pulse_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_in,
  output logic db
);
  logic sync1, sync2;
  logic [7:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt <= 8'd0;
      db <= 1'b0;
    end else begin
      sync1 <= raw_in;
      sync2 <= sync1;
      if (sync2 == db) cnt <= 8'd0;
      else if (cnt == 8'(DEBOUNCE_CYCLES - 1)) begin
        db <= sync2;
        cnt <= 8'd0;
      end else cnt <= cnt + 8'd1;
    end
endmodule

// File: rtl/sr_pulse_gen.sv
// sr_pulse_gen: debounced switch inputs set_raw/reset_raw -> exclusive PULSE_W-wide s/r pulses, e high in INIT, sticky conflict
module sr_pulse_gen
  import sr_pulse_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int PULSE_W = DEF_PULSE_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_raw,
  input  logic reset_raw,
  output logic s,
  output logic r,
  output logic e,
  output logic conflict
);
  state_t state;
  logic set_db, reset_db, set_q, reset_q;
  logic [3:0] cnt;
  logic set_rise, reset_rise;
  sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set_db (
    .clk(clk), .rst_n(rst_n), .raw_in(set_raw), .db(set_db)
  );
  sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_reset_db (
    .clk(clk), .rst_n(rst_n), .raw_in(reset_raw), .db(reset_db)
  );
  // edge detect against last cycle's level, so a level held high into IDLE is no rise
  assign set_rise = set_db & ~set_q;
  assign reset_rise = reset_db & ~reset_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= INIT;
      s <= 1'b0;
      r <= 1'b0;
      e <= 1'b1;
      conflict <= 1'b0;
      cnt <= 4'd0;
      set_q <= 1'b0;
      reset_q <= 1'b0;
    end else begin
      set_q <= set_db;
      reset_q <= reset_db;
      case (state)
        INIT: begin
          state <= IDLE;
          e <= 1'b0;
        end
        IDLE:
          if (set_rise && reset_rise) begin
            state <= WAIT_REL;
            conflict <= 1'b1;
          end else if (set_rise) begin
            state <= PULSE_S;
            s <= 1'b1;
            cnt <= 4'd0;
          end else if (reset_rise) begin
            state <= PULSE_R;
            r <= 1'b1;
            cnt <= 4'd0;
          end
        PULSE_S, PULSE_R:
          if (cnt == 4'(PULSE_W - 1)) begin
            state <= WAIT_REL;
            s <= 1'b0;
            r <= 1'b0;
          end else cnt <= cnt + 4'd1;
        WAIT_REL: if (!set_db && !reset_db) state <= IDLE;
        default: state <= INIT;
      endcase
    end
endmodule

// File: tb/tb_sr_pulse_gen.sv
// tb_sr_pulse_gen: directed table plus hand sequences for sr_pulse_gen with DEBOUNCE_CYCLES=4, PULSE_W=2
module tb_sr_pulse_gen;
  logic clk = 1'b0;
  logic rst_n, set_raw, reset_raw;
  logic s, r, e, conflict;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct {
    logic rn, sr, rr, xs, xr, xe, xc;
  } vec_t;
  vec_t tbl[64];
  int n_vec = 0;
  sr_pulse_gen #(.DEBOUNCE_CYCLES(4), .PULSE_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .set_raw(set_raw), .reset_raw(reset_raw),
    .s(s), .r(r), .e(e), .conflict(conflict)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic add(input logic rn, sr, rr, xs, xr, xe, xc);
    tbl[n_vec] = '{rn, sr, rr, xs, xr, xe, xc};
    n_vec++;
  endtask
  // raw levels held for n edges; ps/pr give the edge on which a 2-clock pulse starts (0 = none)
  task automatic run(input logic sr, rr, input int n, input int ps, input int pr);
    for (int k = 1; k <= n; k++) begin
      set_raw = sr;
      reset_raw = rr;
      cycle();
      chk("run_s", s, ps > 0 && (k == ps || k == ps + 1));
      chk("run_r", r, pr > 0 && (k == pr || k == pr + 1));
    end
  endtask
  initial begin
    rst_n = 1'b0;
    set_raw = 1'b0;
    reset_raw = 1'b0;
    @(negedge clk);
    chk("rst_e_async", e, 1'b1);
    repeat (3) begin
      cycle();
      chk("rst_s", s, 1'b0);
      chk("rst_r", r, 1'b0);
      chk("rst_e", e, 1'b1);
      chk("rst_conflict", conflict, 1'b0);
    end
    rst_n = 1'b1;
    #1 chk("init_e_high", e, 1'b1);
    cycle();
    chk("init_e_low", e, 1'b0);
    chk("init_s", s, 1'b0);
    chk("init_conflict", conflict, 1'b0);
    for (int k = 1; k <= 10; k++) add(1, 1, 0, k == 7 || k == 8, 0, 0, 0);
    for (int k = 1; k <= 10; k++) add(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n_vec; i++) begin
      rst_n = tbl[i].rn;
      set_raw = tbl[i].sr;
      reset_raw = tbl[i].rr;
      cycle();
      chk("tbl_s", s, tbl[i].xs);
      chk("tbl_r", r, tbl[i].xr);
      chk("tbl_e", e, tbl[i].xe);
      chk("tbl_conflict", conflict, tbl[i].xc);
    end
    for (int k = 0; k < 12; k++) begin
      reset_raw = ((k / 2) % 2) == 0;
      cycle();
      chk("bounce_r", r, 1'b0);
      chk("bounce_s", s, 1'b0);
    end
    run(0, 1, 10, 0, 7);
    run(0, 0, 10, 0, 0);
    run(1, 1, 10, 0, 0);
    chk("conflict_set", conflict, 1'b1);
    run(0, 0, 10, 0, 0);
    chk("conflict_sticky", conflict, 1'b1);
    rst_n = 1'b0;
    #1 chk("conflict_cleared", conflict, 1'b0);
    cycle();
    rst_n = 1'b1;
    cycle();
    run(1, 0, 10, 7, 0);
    run(1, 1, 10, 0, 0);
    run(0, 0, 10, 0, 0);
    run(0, 1, 10, 0, 7);
    run(0, 0, 10, 0, 0);
    chk("busy_no_conflict", conflict, 1'b0);
    run(1, 0, 7, 7, 0);
    set_raw = 1'b0;
    rst_n = 1'b0;
    #1 chk("midpulse_s_drop", s, 1'b0);
    chk("midpulse_e", e, 1'b1);
    repeat (3) begin
      cycle();
      chk("midpulse_hold_s", s, 1'b0);
    end
    rst_n = 1'b1;
    run(0, 0, 15, 0, 0);
    chk("midpulse_e_low", e, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  always @(negedge clk) if (s && r) begin
    n_fail++;
    $display("FAIL s_and_r: got 11 expected not 11 at %0t", $time);
  end
endmodule

// File: doc/sr_pulse_gen.md
SR_PULSE_GEN -- requirements
Module: sr_pulse_gen

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive stable synchronized samples needed to accept a level change; legal range 2..255.
REQ-002 SHALL have parameter PULSE_W, default 1: clocks each s/r pulse is held; legal range 1..15.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port set_raw, input, 1: asynchronous, bouncing set request from a switch.
REQ-006 SHALL have port reset_raw, input, 1: asynchronous, bouncing reset request from a switch.
REQ-007 SHALL have port s, output, 1: registered set pulse to the downstream SR latch.
REQ-008 SHALL have port r, output, 1: registered reset pulse to the downstream SR latch.
REQ-009 SHALL have port e, output, 1: registered latch-enable override; high forces the downstream latch to its cleared state.
REQ-010 SHALL have port conflict, output, 1: sticky flag for a simultaneous set/reset request.

Function
REQ-011 SHALL pass each raw input through a two-flop synchronizer before any other use.
REQ-012 SHALL debounce each channel with its own counter: clear when sync == debounced; increment when different; flip debounced and clear when count reaches DEBOUNCE_CYCLES-1 while still different.
REQ-013 SHALL, on a debounced rising edge, assert the matching s or r exactly on the (DEBOUNCE_CYCLES+3)th rising clk edge after raw is first sampled high and stays stable.
REQ-014 SHALL hold each s or r pulse for exactly PULSE_W clocks, then drive it low.
REQ-015 SHALL never drive s and r high in the same cycle; {s,r} = 2'b11 is illegal.
REQ-016 SHALL use FSM states INIT, IDLE, PULSE_S, PULSE_R, WAIT_REL.
REQ-017 SHALL transition INIT->IDLE unconditionally after one clock, with e=1 only in INIT.
REQ-018 SHALL transition IDLE->PULSE_S on a debounced set rise alone, and IDLE->PULSE_R on a debounced reset rise alone.
REQ-019 SHALL, on debounced set and reset rises in the same cycle, go IDLE->WAIT_REL, emit no pulse, and set conflict.
REQ-020 SHALL transition PULSE_S or PULSE_R -> WAIT_REL after PULSE_W clocks.
REQ-021 SHALL transition WAIT_REL->IDLE only when both debounced levels are 0, ignoring all rises while in WAIT_REL and PULSE_*.
REQ-022 SHALL treat a debounced level already high on entry to IDLE as not a rise; a new press requires release first.
REQ-023 SHALL keep conflict high until rst_n is asserted.

Reset
REQ-024 SHALL, while rst_n=0, asynchronously force s=0, r=0, e=1, conflict=0, state=INIT, counters=0, and synchronizer and debounced flops=0.
REQ-025 SHALL, on rst_n deassertion, hold e=1 for exactly one clk edge (INIT), then drive e=0.
REQ-026 SHALL, on reset asserted mid-pulse, drop s/r immediately and emit no pulse after release until a fresh debounced rise.

Structure
REQ-027 SHALL place the state enum and default parameter constants in shared package sr_pulse_pkg.
REQ-028 SHALL implement synchronizer plus debounce as sub-module sr_debounce, instantiated once per channel; FSM and outputs in the top.

Verification
REQ-029 SHALL cover reset release: rst_n low 3 clks then high -> e=1 for 1 clk, then e=0; s=r=conflict=0 throughout.
REQ-030 SHALL cover a clean set, with DEBOUNCE_CYCLES=4, PULSE_W=2: set_raw high and held -> s high on edges 7-8 after first sample, r stays 0.
REQ-031 SHALL cover bounce: reset_raw toggling every 2 clks for 12 clks, then stable high -> single r pulse 7 edges after stabilization; none during bounce.
REQ-032 SHALL cover simultaneous press: set_raw and reset_raw rise on the same edge -> no s/r pulse, conflict=1 and stays 1 after release until reset.
REQ-033 SHALL cover press-while-busy: reset_raw pressed while set still held -> no r; after both released and reset_raw pressed again -> r pulse.
REQ-034 SHALL cover mid-pulse reset: rst_n low during an s pulse -> s=0 immediately; e=1; no pulse after release with inputs low.
